// File: rtl/byte_word_packer.sv
// ============================================================================
// Module   : byte_word_packer
// Purpose  : Packs four zero-extended byte results into one 32-bit word, with
//            early flush of a partial word and per-lane byte enables.
//            Optional macro: PACKER_ZERO_EXT_CHECK_EN (adds sticky err port).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_word_packer #(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_word,
    output logic [3:0]       out_byte_en,
    output logic [CNT_W-1:0] out_count
`ifdef PACKER_ZERO_EXT_CHECK_EN
    ,
    output logic             err
`endif
);

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [N-1:0]     acc_q, acc_d;
    logic [3:0]       en_q, en_d;
    logic [N-1:0]     out_word_q, out_word_d;
    logic [3:0]       out_be_q, out_be_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;

    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_complete;
    logic [N-1:0]     w_acc_merged;
    logic [3:0]       w_en_merged;

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;
    assign w_complete = w_in_xfer && ((ptr_q == 2'd3) || in_last);

    // ------------------------------------------------------------------
    // Output-side FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // A completion in the same cycle as a drain reloads the holding slot.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL: begin
                if (w_complete) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_complete) begin
                    state_d = S_HOLD;
                end else if (out_ready) begin
                    state_d = S_FILL;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    always_comb begin
        out_valid = (state_q == S_HOLD);
        in_ready  = !out_valid || out_ready;
    end

    // ------------------------------------------------------------------
    // Accumulator lane merge
    // ------------------------------------------------------------------
    always_comb begin
        w_acc_merged                        = acc_q;
        w_acc_merged[{ptr_q, 3'b000} +: 8]  = in_data[7:0];
        w_en_merged                         = en_q | (4'b0001 << ptr_q);
    end

    always_comb begin
        acc_d = acc_q;
        en_d  = en_q;
        ptr_d = ptr_q;
        if (w_in_xfer) begin
            if (w_complete) begin
                acc_d = '0;
                en_d  = '0;
                ptr_d = '0;
            end else begin
                acc_d = w_acc_merged;
                en_d  = w_en_merged;
                ptr_d = ptr_q + 2'd1;
            end
        end
    end

    always_comb begin
        out_word_d  = out_word_q;
        out_be_d    = out_be_q;
        out_count_d = out_count_q + {{(CNT_W-1){1'b0}}, w_out_xfer};
        if (w_complete) begin
            out_word_d = w_acc_merged;
            out_be_d   = w_en_merged;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            acc_q       <= '0;
            en_q        <= '0;
            out_word_q  <= '0;
            out_be_q    <= '0;
            out_count_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            acc_q       <= acc_d;
            en_q        <= en_d;
            out_word_q  <= out_word_d;
            out_be_q    <= out_be_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_word    = out_word_q;
    assign out_byte_en = out_be_q;
    assign out_count   = out_count_q;

`ifdef PACKER_ZERO_EXT_CHECK_EN
    logic err_q, err_d;

    // Sticky flag: any accepted byte with non-zero upper bits.
    assign err_d = err_q || (w_in_xfer && (|in_data[N-1:8]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic w_unused_upper;
    assign w_unused_upper = ^in_data[N-1:8];
`endif

endmodule

`default_nettype wire
